// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding and framing constants for the SCCB write master.
package sccb_pkg;
  typedef enum logic [2:0] {IDLE, START, TX, DC, STOP, STOP_END} state_t;
  localparam int BITS_PER_PHASE = 9;
  localparam int DEF_NUM_PHASES = 3;
endpackage

// File: rtl/sccb_tx_shifter.sv
// sccb_tx_shifter: parallel-load MSB-first shifter with bit/byte position counters.
module sccb_tx_shifter
  import sccb_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  localparam int W  = 8 * NUM_PHASES,
  localparam int BW = $clog2(NUM_PHASES + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  data,
  output logic          msb,
  output logic [3:0]    bit_cnt,
  output logic [BW-1:0] byte_cnt
);
  logic [W-1:0] sr;
  logic         wrap;
  assign msb  = sr[W-1];
  assign wrap = bit_cnt == 4'(BITS_PER_PHASE - 1);
  // a shift after the eighth bit starts the next byte, so bit_cnt wraps to 1, not 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      sr       <= data;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      sr       <= sr << 1;
      bit_cnt  <= wrap ? 4'd1 : bit_cnt + 4'd1;
      byte_cnt <= wrap ? byte_cnt + BW'(1) : byte_cnt;
    end
  end
endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB 3-phase write master stepping on mid-low strobes of an external SCCB clock.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sccb_clk,
  input  logic       mid_pulse,
  input  logic       start,
  input  logic [7:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sio_d_in,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);
  localparam int W  = 8 * NUM_PHASES;
  localparam int BW = $clog2(NUM_PHASES + 1);
  state_t          state, state_nxt;
  logic            gate, gate_nxt, sio_d_nxt, oe_nxt, busy_nxt, done_nxt, nack_nxt;
  logic            load, shift, msb;
  logic [3:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [W-1:0]    payload;
  assign payload = W'({dev_addr, reg_addr, wr_data, {W{1'b0}}} >> 24);
  sccb_tx_shifter #(.NUM_PHASES(NUM_PHASES)) u_shift (
    .clk(clk), .resetn(resetn), .load(load), .shift(shift), .data(payload),
    .msb(msb), .bit_cnt(bit_cnt), .byte_cnt(byte_cnt)
  );
  // START uses sio_d_out itself to tell its first strobe (line still high) from its second
  always_comb begin
    state_nxt = state;
    gate_nxt  = gate;
    sio_d_nxt = sio_d_out;
    oe_nxt    = sio_d_oe;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    nack_nxt  = nack;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        nack_nxt  = 1'b0;
        busy_nxt  = 1'b1;
        state_nxt = START;
      end
      START: if (mid_pulse) begin
        if (sio_d_out) sio_d_nxt = 1'b0;
        else begin
          gate_nxt  = 1'b1;
          sio_d_nxt = msb;
          shift     = 1'b1;
          state_nxt = TX;
        end
      end
      TX: if (mid_pulse) begin
        if (bit_cnt == 4'(BITS_PER_PHASE - 1)) begin
          oe_nxt    = 1'b0;
          state_nxt = DC;
        end else begin
          sio_d_nxt = msb;
          shift     = 1'b1;
        end
      end
      DC: if (mid_pulse) begin
        oe_nxt   = 1'b1;
        nack_nxt = nack | sio_d_in;
        if (byte_cnt == BW'(NUM_PHASES - 1)) begin
          sio_d_nxt = 1'b0;
          state_nxt = STOP;
        end else begin
          sio_d_nxt = msb;
          shift     = 1'b1;
          state_nxt = TX;
        end
      end
      STOP: if (mid_pulse) begin
        gate_nxt  = 1'b0;
        state_nxt = STOP_END;
      end
      STOP_END: if (mid_pulse) begin
        sio_d_nxt = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      gate      <= 1'b0;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      state     <= state_nxt;
      gate      <= gate_nxt;
      sio_c     <= gate_nxt ? sccb_clk : 1'b1;
      sio_d_out <= sio_d_nxt;
      sio_d_oe  <= oe_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      nack      <= nack_nxt;
    end
  end
endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: scoreboard bench decoding the SCCB bus on every sio_c rise.
module tb_sccb_master;
  logic       clk = 1'b0, resetn = 1'b1, sccb_clk = 1'b0, mid_pulse = 1'b0, start = 1'b0;
  logic [7:0] dev_addr = '0, reg_addr = '0, wr_data = '0;
  logic       sio_d_in, sio_c, sio_d_out, sio_d_oe, busy, done, nack;
  int checks = 0, errors = 0;
  int sym_q[$];
  bit nack_q[$];
  int mp_cnt = 0, sym_cnt = 0, start_cnt = 0, stop_cnt = 0, dc_idx = 0, done_cnt = 0, nack_dc = 0;
  logic prev_c = 1'b1, prev_d = 1'b1, prev_oe = 1'b1;

  sccb_master dut (
    .clk(clk), .resetn(resetn), .sccb_clk(sccb_clk), .mid_pulse(mid_pulse), .start(start),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data), .sio_d_in(sio_d_in),
    .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe), .busy(busy), .done(done), .nack(nack)
  );

  // the slave answers high only during the selected don't-care slot (1-based)
  assign sio_d_in = !sio_d_oe && (dc_idx == nack_dc);

  always #5 clk = ~clk;

  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      cnt       = (cnt + 1) % 8;
      sccb_clk  = (cnt >= 4);
      mid_pulse = (cnt == 2);
    end
  end

  always @(negedge clk) begin : monitor
    int sym, e;
    bit en;
    if (!resetn) begin
      prev_c = 1'b1; prev_d = 1'b1; prev_oe = 1'b1;
      mp_cnt = 0; sym_cnt = 0; start_cnt = 0; stop_cnt = 0; dc_idx = 0;
    end else begin
      if (mid_pulse && busy) mp_cnt++;
      if (!sio_d_oe && prev_oe) dc_idx++;
      if (sio_c && prev_c && sio_d_oe && prev_oe && prev_d && !sio_d_out) start_cnt++;
      if (sio_c && prev_c && sio_d_oe && prev_oe && !prev_d && sio_d_out) stop_cnt++;
      if (sio_c && !prev_c) begin
        sym = sio_d_oe ? int'(sio_d_out) : 2;
        checks++;
        if (sym_q.size() == 0) begin
          errors++;
          $display("FAIL bit_stream: unexpected sio_c rise, got %0d, required no clock", sym);
        end else begin
          e = sym_q.pop_front();
          if (sym !== e) begin
            errors++;
            $display("FAIL bit_stream[%0d]: got %0d, required %0d (2 = released)", sym_cnt, sym, e);
          end
        end
        sym_cnt++;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (nack_q.size() == 0) begin
          errors++;
          $display("FAIL done: got unexpected done strobe, required none");
        end else begin
          en = nack_q.pop_front();
          checks++;
          if (nack !== en) begin errors++; $display("FAIL nack: got %0b, required %0b", nack, en); end
          checks++;
          if (mp_cnt !== 31) begin errors++; $display("FAIL txn_length: got %0d mid_pulses, required 31", mp_cnt); end
          checks++;
          if (sym_cnt !== 29) begin errors++; $display("FAIL clock_count: got %0d sio_c rises, required 29", sym_cnt); end
          checks++;
          if (start_cnt !== 1 || stop_cnt !== 1) begin
            errors++;
            $display("FAIL start_stop: got %0d starts %0d stops, required 1 and 1", start_cnt, stop_cnt);
          end
        end
        mp_cnt = 0; sym_cnt = 0; start_cnt = 0; stop_cnt = 0; dc_idx = 0;
      end
      prev_c = sio_c; prev_d = sio_d_out; prev_oe = sio_d_oe;
    end
  end

  task automatic push_txn(input logic [7:0] d, input logic [7:0] r, input logic [7:0] w, input bit nk);
    logic [23:0] p;
    p = {d, r, w};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) sym_q.push_back(int'(p[23 - 8 * b - i]));
      sym_q.push_back(2);
    end
    sym_q.push_back(0);
    sym_q.push_back(0);
    nack_q.push_back(nk);
  endtask

  task automatic issue(input logic [7:0] d, input logic [7:0] r, input logic [7:0] w, input bit nk);
    @(posedge clk); #1;
    dev_addr = d; reg_addr = r; wr_data = w; start = 1'b1;
    push_txn(d, r, w, nk);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t  = done_cnt + 1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= t) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_mp(input int n);
    for (int i = 0; i < 400 && mp_cnt < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset;
    #2 resetn = 1'b0;
    #1;
    checks++; if (sio_c !== 1'b1)     begin errors++; $display("FAIL reset_sio_c: got %b, required 1", sio_c); end
    checks++; if (sio_d_out !== 1'b1) begin errors++; $display("FAIL reset_sio_d: got %b, required 1", sio_d_out); end
    checks++; if (sio_d_oe !== 1'b1)  begin errors++; $display("FAIL reset_oe: got %b, required 1", sio_d_oe); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (nack !== 1'b0)      begin errors++; $display("FAIL reset_nack: got %b, required 0", nack); end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (sio_c !== 1'b1 || sio_d_out !== 1'b1 || sio_d_oe !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle: got c=%b d=%b oe=%b busy=%b, required 1 1 1 0", sio_c, sio_d_out, sio_d_oe, busy);
      end
    end
  endtask

  task automatic test_basic;
    bit ok;
    issue(8'h42, 8'h12, 8'h80, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done, required done"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_nack;
    bit ok;
    nack_dc = 2;
    issue(8'h21, 8'h3c, 8'ha5, 1'b1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_timeout: got no done, required done"); end
    nack_dc = 0;
    repeat (5) @(negedge clk);
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_hold: got %b, required 1", nack); end
    issue(8'h42, 8'h55, 8'h0f, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_clear_timeout: got no done, required done"); end
  endtask

  task automatic test_ignore;
    bit ok;
    issue(8'h42, 8'h12, 8'h80, 1'b0);
    wait_mp(5);
    dev_addr = 8'hff; reg_addr = 8'hff; wr_data = 8'hff;
    wait_mp(10);
    @(posedge clk); #1;
    dev_addr = 8'h00; reg_addr = 8'h00; wr_data = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b, required 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout: got no done, required done"); end
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_extra: got busy %b, required 0", busy); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(posedge clk); #1;
    dev_addr = 8'h42; reg_addr = 8'h6b; wr_data = 8'h3a; start = 1'b1;
    push_txn(8'h42, 8'h6b, 8'h3a, 1'b0);
    @(posedge clk); #1;
    dev_addr = 8'h43; reg_addr = 8'h94; wr_data = 8'hc5;
    push_txn(8'h43, 8'h94, 8'hc5, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no done, required done"); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b, required 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no done, required done"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    issue(8'h42, 8'h12, 8'h80, 1'b0);
    wait_mp(15);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (sio_c !== 1'b1 || sio_d_out !== 1'b1 || sio_d_oe !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got c=%b d=%b oe=%b busy=%b done=%b, required 1 1 1 0 0",
               sio_c, sio_d_out, sio_d_oe, busy, done);
    end
    sym_q.delete();
    nack_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    issue(8'h5a, 8'hc3, 8'h01, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_recover_timeout: got no done, required done"); end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_basic;
    test_nack;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    repeat (20) @(negedge clk);
    checks++;
    if (sym_q.size() != 0 || nack_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d symbols %0d txns left, required 0", sym_q.size(), nack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 The module SHALL have parameter NUM_PHASES, default 3, meaning bytes per write transaction: ID, sub-address, data.
REQ-002 The module SHALL have port clk, input, 1, system clock; the only clock used by the block.
REQ-003 The module SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-004 The module SHALL have port sccb_clk, input, 1, free-running SCCB-rate clock, synchronous to clk.
REQ-005 The module SHALL have port mid_pulse, input, 1, one-clk strobe at mid-point of sccb_clk low phase.
REQ-006 The module SHALL have port start, input, 1, transaction request.
REQ-007 The module SHALL have ports dev_addr, reg_addr and wr_data, input, 8 each, holding ID (write), sub-address and data.
REQ-008 The module SHALL have port sio_d_in, input, 1, sampled SIO_D pad value.
REQ-009 The module SHALL have port sio_c, output, 1, SIO_C pad drive.
REQ-010 The module SHALL have port sio_d_out, output, 1, SIO_D drive value.
REQ-011 The module SHALL have port sio_d_oe, output, 1, SIO_D output enable (1 = drive).
REQ-012 The module SHALL have port busy, output, 1, transaction in progress.
REQ-013 The module SHALL have port done, output, 1, one-clk completion strobe.
REQ-014 The module SHALL have port nack, output, 1, high if any don't-care bit sampled high in the last transaction.

Function
REQ-015 The FSM SHALL have states IDLE, START, TX, DC (don't-care bit), STOP, STOP_END, and SHALL advance only on clk cycles where mid_pulse=1, except IDLE.
REQ-016 In IDLE with start=1 the block SHALL latch {dev_addr,reg_addr,wr_data}, clear nack, set busy next cycle and enter START; start while busy SHALL be ignored.
REQ-017 START, 1st mid_pulse: sio_d_out SHALL go to 0 with sio_c held 1 (start condition).
REQ-018 START, 2nd mid_pulse: sio_c SHALL begin following sccb_clk, sio_d_out SHALL take the MSB of byte 0, and the FSM SHALL enter TX.
REQ-019 TX: each mid_pulse SHALL present the next bit MSB-first; after bit 0 has been presented, the next mid_pulse SHALL enter DC with sio_d_oe=0.
REQ-020 DC: at the mid_pulse that exits DC, sio_d_in SHALL be sampled and nack set if 1; sio_d_oe SHALL return to 1.
REQ-021 On exit from DC, the FSM SHALL go to TX with the next byte's MSB presented, or to STOP with sio_d_out=0 after byte NUM_PHASES-1.
REQ-022 STOP, next mid_pulse: sio_c SHALL be forced to 1 and the FSM SHALL enter STOP_END.
REQ-023 STOP_END, next mid_pulse: sio_d_out SHALL go to 1 (stop condition), the FSM SHALL enter IDLE, and in that same clk busy SHALL go to 0 and done SHALL equal 1 for exactly one cycle.
REQ-024 A start presented in the cycle done=1 SHALL be accepted.
REQ-025 Transaction length SHALL be exactly 2 + 9*NUM_PHASES + 2 mid_pulses (31 for default), measured from acceptance to done.
REQ-026 sio_c SHALL be registered: sio_c = gate ? sccb_clk : 1, delayed one clk.
REQ-027 In IDLE: sio_c=1, sio_d_out=1, sio_d_oe=1, and mid_pulse SHALL be ignored.
REQ-028 Input changes on dev_addr, reg_addr and wr_data during busy SHALL NOT affect the transaction.

Reset
REQ-029 On resetn=0, all outputs SHALL take IDLE values immediately: sio_c=1, sio_d_out=1, sio_d_oe=1, busy=0, done=0, nack=0, and the state SHALL be IDLE.
REQ-030 Reset mid-transaction SHALL abort without a stop condition; the next start after release SHALL begin a clean transaction.

Structure
REQ-031 Package sccb_pkg SHALL hold the state enum, BITS_PER_PHASE=9 and the default NUM_PHASES.
REQ-032 Sub-module sccb_tx_shifter (parallel-load 8*NUM_PHASES-bit MSB-first shifter with bit/byte counters) SHALL be used.
REQ-033 Both sccb_master and sccb_tx_shifter SHALL be single-clock and free of combinational outputs.

Verification
REQ-034 dev 0x42, reg 0x12, data 0x80, mid_pulse every 8 clks -> sio_d sequence 0100_0010_Z 0001_0010_Z 1000_0000_Z, start/stop correct, done once after 31 mid_pulses.
REQ-035 sio_d_in=1 during the second DC only -> nack=1 after done; next transaction with sio_d_in=0 -> nack=0.
REQ-036 start held high continuously -> back-to-back transactions, start accepted on the done cycle, with no extra idle mid_pulse.
REQ-037 start pulsed at transaction mid_pulse 10 -> ignored; data changes at mid_pulse 5 -> bit stream unchanged.
REQ-038 resetn low during TX byte 1 -> outputs 1/1/1 and busy=0 in the same cycle; new transaction completes normally.
REQ-039 mid_pulse toggling with start=0 -> sio_c=1, sio_d=1 and no done.
